// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, ram_ctrl fields,
// FSM states and the stall-counter width.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int unsigned CTRL_E     = 0;
  localparam int unsigned CTRL_WB    = 1;
  localparam int unsigned CTRL_SZ_LO = 2;
  localparam int unsigned CTRL_SZ_HI = 3;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return ((size == SZ_HALF) && lsb[0]) || ((size == SZ_WORD) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Big-endian lane steering: lane k is byte address addr+k. Loads are extracted and
// zero-extended; stores produce per-lane enables and positioned bytes.
module dmem_byte_lane
  import dmem_pkg::*;
(
  input  logic [1:0]      size,
  input  logic [31:0]     wdata,
  input  logic [3:0][7:0] rd_bytes,
  output logic [31:0]     load_data,
  output logic [3:0]      be,
  output logic [3:0][7:0] wr_bytes
);

  always_comb begin
    load_data = '0;
    be        = '0;
    wr_bytes  = '0;
    case (size)
      SZ_BYTE: begin
        load_data   = {24'h0, rd_bytes[0]};
        be          = 4'b0001;
        wr_bytes[0] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data   = {16'h0, rd_bytes[0], rd_bytes[1]};
        be          = 4'b0011;
        wr_bytes[0] = wdata[15:8];
        wr_bytes[1] = wdata[7:0];
      end
      SZ_WORD: begin
        load_data   = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};
        be          = 4'b1111;
        wr_bytes[0] = wdata[31:24];
        wr_bytes[1] = wdata[23:16];
        wr_bytes[2] = wdata[15:8];
        wr_bytes[3] = wdata[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed big-endian data memory with a fixed-latency request/ack handshake.
// Optional DMEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with err.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ram_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        ack,
  output logic        err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  logic [7:0] mem [2**ADDR_W];

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         size_q;
  logic               wb_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic               busy_q, ack_q, err_q;
  logic [31:0]        dout_q;

  logic [ADDR_W-1:0]  lane_addr [4];
  logic [3:0][7:0]    rd_bytes;
  logic [3:0][7:0]    wr_bytes;
  logic [3:0]         be;
  logic [31:0]        load_data;
  logic               access_err;
  logic               unused_addr;

  assign unused_addr = ^addr[31:ADDR_W];

  // Lanes wrap naturally through the ADDR_W-bit truncation.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = addr_q + ADDR_W'(k);
      rd_bytes[k]  = mem[lane_addr[k]];
    end
  end

  dmem_byte_lane u_lane (
    .size      (size_q),
    .wdata     (wdata_q),
    .rd_bytes  (rd_bytes),
    .load_data (load_data),
    .be        (be),
    .wr_bytes  (wr_bytes)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  assign access_err = (size_q == SZ_RSVD) || misaligned(size_q, addr_q[1:0]);
`else
  assign access_err = (size_q == SZ_RSVD);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      size_q  <= SZ_BYTE;
      wb_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // busy is still high only during the ack cycle; no acceptance then.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (ram_ctrl[CTRL_E]) begin
            size_q  <= ram_ctrl[CTRL_SZ_HI:CTRL_SZ_LO];
            wb_q    <= ram_ctrl[CTRL_WB];
            addr_q  <= addr[ADDR_W-1:0];
            wdata_q <= data_in;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= StDone;
            end else begin
              state_q <= StWait;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        StWait: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_q   <= '0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StDone: begin
          ack_q   <= 1'b1;
          err_q   <= access_err;
          state_q <= StIdle;
          if (access_err) begin
            dout_q <= '0;
          end else if (!wb_q) begin
            dout_q <= load_data;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory is not reset; the write is gated so a reset at the DONE edge aborts it.
  always_ff @(posedge clk) begin
    if (!reset && state_q == StDone && wb_q && !access_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[lane_addr[k]] <= wr_bytes[k];
      end
    end
  end

  assign data_out = dout_q;
  assign busy     = busy_q;
  assign ack      = ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed vector table plus hand-written reset, ignored-request and back-to-back sequences.
module tb_data_mem_responder;

  localparam int unsigned WAIT_CYCLES = 1;
  localparam int LAT = WAIT_CYCLES + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ram_ctrl;
  logic [31:0] addr, data_in, data_out;
  logic        busy, ack, err;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .ram_ctrl (ram_ctrl),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .ack      (ack),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    logic        exp_err;
    logic        chk;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [3:0] c, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] e, input logic ee,
                              input logic chk);
    vec_t v;
    v.name = n; v.ctrl = c; v.a = a; v.d = d; v.exp = e; v.exp_err = ee; v.chk = chk;
    return v;
  endfunction

  // One complete transaction: acceptance edge, bounded wait for ack, then the busy-clear edge.
  task automatic run_req(input vec_t v);
    int lat;
    @(negedge clk);
    ram_ctrl = v.ctrl; addr = v.a; data_in = v.d;
    @(posedge clk); #1;
    check({v.name, ".busy_acc"}, 32'(busy), 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 20);
    ram_ctrl = 4'b0;
    check({v.name, ".lat"}, 32'(lat), 32'(LAT));
    check({v.name, ".err"}, 32'(err), 32'(v.exp_err));
    if (v.chk) check({v.name, ".dout"}, data_out, v.exp);
    check({v.name, ".busy_ack"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({v.name, ".ack_pulse"}, 32'(ack), 32'd0);
    check({v.name, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int acks, lat;
    logic [31:0] cap;

    reset = 1'b1; ram_ctrl = 4'b0; addr = '0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.ack", 32'(ack), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.dout", data_out, 32'd0);
    @(negedge clk); reset = 1'b0;

    vecs.push_back(mk("stw10", 4'b1011, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk("ldw10", 4'b1001, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1));
    vecs.push_back(mk("ldb11", 4'b0001, 32'h11, 32'h0, 32'h000000AD, 1'b0, 1'b1));
    vecs.push_back(mk("ldh12", 4'b0101, 32'h12, 32'h0, 32'h0000BEEF, 1'b0, 1'b1));
    vecs.push_back(mk("stb13", 4'b0011, 32'h13, 32'h00000055, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk("ldw10b", 4'b1001, 32'h10, 32'h0, 32'hDEADBE55, 1'b0, 1'b1));
    vecs.push_back(mk("ldw_hi", 4'b1001, 32'h00000110, 32'h0, 32'hDEADBE55, 1'b0, 1'b1));
    vecs.push_back(mk("stw20", 4'b1011, 32'h20, 32'h01020304, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk("sth22", 4'b0111, 32'h22, 32'h1234A5C3, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk("ldw20", 4'b1001, 32'h20, 32'h0, 32'h0102A5C3, 1'b0, 1'b1));
    vecs.push_back(mk("rsv_ld", 4'b1101, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1));
    vecs.push_back(mk("rsv_st", 4'b1111, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1));
    vecs.push_back(mk("ldw10c", 4'b1001, 32'h10, 32'h0, 32'hDEADBE55, 1'b0, 1'b1));
`ifdef DMEM_ALIGN_CHECK_EN
    vecs.push_back(mk("mis_ldw", 4'b1001, 32'h11, 32'h0, 32'h0, 1'b1, 1'b1));
    vecs.push_back(mk("mis_ldh", 4'b0101, 32'h13, 32'h0, 32'h0, 1'b1, 1'b1));
    vecs.push_back(mk("mis_stw", 4'b1011, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1));
    vecs.push_back(mk("mis_chk", 4'b1001, 32'h10, 32'h0, 32'hDEADBE55, 1'b0, 1'b1));
`else
    vecs.push_back(mk("wrap_st", 4'b1011, 32'hFF, 32'h11223344, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk("wrap_ff", 4'b0001, 32'hFF, 32'h0, 32'h00000011, 1'b0, 1'b1));
    vecs.push_back(mk("wrap_00", 4'b0001, 32'h00, 32'h0, 32'h00000022, 1'b0, 1'b1));
    vecs.push_back(mk("wrap_01", 4'b0001, 32'h01, 32'h0, 32'h00000033, 1'b0, 1'b1));
    vecs.push_back(mk("wrap_02", 4'b0001, 32'h02, 32'h0, 32'h00000044, 1'b0, 1'b1));
    vecs.push_back(mk("wrap_ldw", 4'b1001, 32'hFF, 32'h0, 32'h11223344, 1'b0, 1'b1));
    vecs.push_back(mk("mis_ldh", 4'b0101, 32'h11, 32'h0, 32'h0000ADBE, 1'b0, 1'b1));
`endif

    foreach (vecs[i]) run_req(vecs[i]);

    // Reset while in WAIT during a store: aborted, no ack, contents intact.
    @(negedge clk);
    ram_ctrl = 4'b1011; addr = 32'h20; data_in = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("rmid.busy_acc", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rmid.busy", 32'(busy), 32'd0);
    check("rmid.ack", 32'(ack), 32'd0);
    check("rmid.dout", data_out, 32'd0);
    ram_ctrl = 4'b0;
    @(negedge clk); reset = 1'b0;
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    check("rmid.no_ack", 32'(acks), 32'd0);
    run_req(mk("rmid.ldw", 4'b1001, 32'h20, 32'h0, 32'h0102A5C3, 1'b0, 1'b1));

    // Second request while busy is ignored; exactly one ack.
    @(negedge clk);
    ram_ctrl = 4'b1001; addr = 32'h10; data_in = 32'h0;
    @(posedge clk);
    @(negedge clk);
    ram_ctrl = 4'b1011; addr = 32'h10; data_in = 32'hCAFEF00D;
    acks = 0; cap = '0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack) begin
        acks++;
        cap = data_out;
        ram_ctrl = 4'b0;
      end
    end
    ram_ctrl = 4'b0;
    check("ign.acks", 32'(acks), 32'd1);
    check("ign.dout", cap, 32'hDEADBE55);
    run_req(mk("ign.ldw", 4'b1001, 32'h10, 32'h0, 32'hDEADBE55, 1'b0, 1'b1));

    // Back-to-back: request held across ack is accepted in the cycle after ack.
    @(negedge clk);
    ram_ctrl = 4'b0001; addr = 32'h10;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 20);
    check("b2b.first", data_out, 32'h000000DE);
    addr = 32'h13;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 20);
    ram_ctrl = 4'b0;
    check("b2b.gap", 32'(lat), 32'(LAT + 2));
    check("b2b.second", data_out, 32'h00000055);
    @(posedge clk); #1;
    check("b2b.busy_end", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
